// File: rtl/sha_chunk_sequencer.sv
// SHA-256 message padder and chunk sequencer.
// Builds the fully padded vector into a register on accept, then streams it
// out MSB-first as 512-bit chunks over a valid/ready handshake.
module sha_chunk_sequencer #(
  parameter int MSG_BITS = 640
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic                msg_mode,
  input  logic [MSG_BITS-1:0] msg_data,
  input  logic [255:0]        digest_in,
  input  logic                abort,
  output logic                chunk_valid,
  input  logic                chunk_ready,
  output logic [511:0]        chunk_data,
  output logic [2:0]          chunk_idx,
  output logic                chunk_first,
  output logic                chunk_last,
  output logic                busy
);

  localparam int NCHUNK = (MSG_BITS + 65 + 511) / 512;
  localparam int PW     = NCHUNK * 512;
  // MSG_BITS is a multiple of 32, so MSG_BITS+65 is odd and K is never 0.
  localparam int K      = PW - MSG_BITS - 65;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] p_reg;
  logic [PW-1:0] p_msg, p_dig;
  logic [2:0]    idx_q;
  logic [2:0]    last_q;
  logic          accept, hshk, final_hs;

  assign accept   = (state_q == IDLE) && msg_valid;
  assign hshk     = (state_q == SEND) && chunk_ready;
  assign final_hs = hshk && (idx_q == last_q);

  // Padded images for both modes; digest pads to a single chunk at the top.
  always_comb begin
    p_msg = {msg_data, 1'b1, {K{1'b0}}, 64'(MSG_BITS)};
    p_dig = '0;
    p_dig[PW-1 -: 512] = {digest_in, 1'b1, 191'b0, 64'd256};
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: abort wins over any handshake or accept in the same cycle.
  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (msg_valid) state_d = SEND;
        SEND:    if (final_hs)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state and the registered chunk index only, so
  // msg_ready never depends on chunk_ready.
  always_comb begin
    msg_ready   = (state_q == IDLE);
    chunk_valid = (state_q == SEND);
    busy        = (state_q == SEND);
    chunk_first = (state_q == SEND) && (idx_q == 3'd0);
    chunk_last  = (state_q == SEND) && (idx_q == last_q);
  end

  // Padded vector and chunk index; chunk 0 always sits in the top 512 bits
  // and each accepted chunk shifts the next one up.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p_reg  <= '0;
      idx_q  <= '0;
      last_q <= '0;
    end else if (abort) begin
      idx_q <= '0;
    end else if (accept) begin
      p_reg  <= msg_mode ? p_dig : p_msg;
      idx_q  <= '0;
      last_q <= msg_mode ? 3'd0 : 3'(NCHUNK - 1);
    end else if (final_hs) begin
      idx_q <= '0;
    end else if (hshk) begin
      idx_q <= idx_q + 3'd1;
      p_reg <= p_reg << 512;
    end
  end

  assign chunk_data = p_reg[PW-1 -: 512];
  assign chunk_idx  = idx_q;

endmodule

// File: doc/sha_chunk_sequencer.md
# sha_chunk_sequencer

Parametrised SHA-256 message padder and chunk sequencer. It accepts one complete message of MSG_BITS bits, or a 256-bit digest for the second pass of a double hash. It applies standard SHA-256 padding: a single 1 bit, zero fill, then the 64-bit big-endian bit length. It then streams the padded result as consecutive 512-bit chunks to the hash core over a valid/ready handshake. It sits between the packet decoder and the SHA-256 compression core and replaces fixed two-chunk selection logic.

## Interface
- MSG_BITS, 640, message length in bits; multiple of 32, range 32..1984.
- NCHUNK (derived, not overridable), ceil((MSG_BITS+65)/512), chunk count in message mode (640 → 2, max 5).
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset; asynchronous and active-low.
- msg_valid  in  1  source offers a message or digest.
- msg_ready  out  1  block can accept; high only in IDLE.
- msg_mode  in  1  0 = message (msg_data), 1 = digest (digest_in); sampled on accept.
- msg_data  in  MSG_BITS  message, MSB first.
- digest_in  in  256  previous hash result, MSB first.
- abort  in  1  synchronous flush to IDLE.
- chunk_valid  out  1  chunk_data holds a valid chunk.
- chunk_ready  in  1  hash core accepts the chunk.
- chunk_data  out  512  current padded chunk, MSB first.
- chunk_idx  out  3  index of the current chunk, 0-based.
- chunk_first  out  1  chunk_idx == 0; core reloads its initial H values.
- chunk_last  out  1  final chunk of this message.
- busy  out  1  state != IDLE.

## Operation
- Padded vector P is {payload, 1'b1, K zeros, 64-bit length}. Its total size is 512·n bits, with K minimal and ≥ 0.
  - Message mode: n = NCHUNK, length = MSG_BITS.
  - Digest mode: n = 1, length = 256, K = 191.
- Chunk k = P[512·n−1−512k -: 512].
- FSM states: IDLE and SEND.
- IDLE:
  - msg_ready = 1.
  - On msg_valid & msg_ready: capture the payload and mode, build P into a register, set chunk_idx = 0, go to SEND.
- SEND:
  - chunk_valid = 1.
  - On chunk_valid & chunk_ready with chunk_idx < n−1: increment chunk_idx.
  - On the same handshake with chunk_idx == n−1: go to IDLE and clear chunk_valid.
- chunk_last = (chunk_idx == n−1) while in SEND; 0 in IDLE.
- chunk_first = (chunk_idx == 0) while in SEND; 0 in IDLE.
- abort:
  - In any state, the next edge forces IDLE, chunk_valid = 0 and chunk_idx = 0.
  - abort overrides a simultaneous chunk handshake or msg accept; neither takes effect.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). The partial message is discarded and no further chunk is emitted.
- chunk_data is don't-care when chunk_valid = 0, but it must be registered, never combinational from msg_data.

## Timing
- Reset values:
  - chunk_valid 0, chunk_first 0, chunk_last 0, busy 0.
  - chunk_idx 0, chunk_data 0.
  - msg_ready 1 (IDLE).
- Latency: accept at edge E, so chunk_valid = 1 with chunk 0 in the cycle after E.
- Backpressure: while chunk_valid & !chunk_ready, the following are held stable:
  - chunk_data, chunk_idx, chunk_first, chunk_last.
- With chunk_ready tied high:
  - One chunk per cycle.
  - msg_ready returns the cycle after the last handshake.
  - Message period is n+1 cycles (640-bit: 3; digest: 2).
- No same-cycle reload: msg_ready is 0 during the cycle the last chunk is handed over.
- msg_ready does not depend combinationally on chunk_ready.

## Test plan
- **640-bit message:** MSG_BITS=640, msg_mode=0, ready high.
  - chunk0 = msg[639:128], first=1.
  - chunk1 = {msg[127:0], 1'b1, 319'b0, 64'd640}, last=1.
  - msg_ready high again 3 cycles after accept.
- **Length boundary:**
  - MSG_BITS=448 gives 2 chunks: chunk0 = {msg, 1'b1, 63'b0}, chunk1 = {448'b0, 64'd448}.
  - MSG_BITS=416 gives 1 chunk: {msg, 1'b1, 31'b0, 64'd416}, with first=last=1.
- **Digest mode:** digest_in = 256'h5DF6…(any value), msg_mode=1.
  - Exactly one chunk: {digest, 1'b1, 191'b0, 64'd256}, first=last=1.
- **Backpressure:** chunk_ready low for 4 cycles on chunk0.
  - chunk_data/idx are stable for all 4 cycles.
  - msg_valid pulses during SEND are ignored (msg_ready=0).
  - Total 2 chunks delivered.
- **abort:** assert abort on the cycle chunk0 handshakes.
  - Next cycle: IDLE, chunk_valid=0, idx=0, msg_ready=1.
  - A new message restarts with chunk_idx=0, first=1.
- **Reset mid-operation:** n_rst low between chunk0 and chunk1.
  - All outputs go to reset values before the next clock edge.
  - After release, no residual chunk is emitted.
